ddr_512b_enc_chk_ctrl: RTL and testbench

//  Sequencer for one self-test run of the encoder checker datapath.
//  - On start: pulses the checker's clear input, then emits cfg_pkt_num sequence-numbered words.
//  - Inserts cfg_gap idle cycles between words, waits a drain window, then judges the checker's counters.
//  - Reports busy / done / pass.

---
 rtl/ddr_enc_chk_pkg.sv | 22 ++
 rtl/ddr_512b_enc_chk_ctrl_if.sv | 29 ++
 rtl/cmip_app_cnt.sv | 23 ++
 rtl/ddr_enc_pat_gen.sv | 62 ++++++
 rtl/ddr_512b_enc_chk_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ddr_512b_enc_chk_ctrl.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/ddr_enc_chk_pkg.sv
// Shared states and constants for the encoder-checker self-test sequencer.
// Optional error injection is built in with ENC_CHK_ERR_INJ_EN.
package ddr_enc_chk_pkg;

    localparam int SEQ_WD = 16;
    localparam int PAT_WD = 48;
    localparam logic [PAT_WD-1:0] PAT = 48'hBBBB_CCCC_DDDD;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND,
        GAP,
        DRAIN,
        EVAL
    } ctrl_st_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_512b_enc_chk_ctrl_if.sv
// Sequencer <-> checker link: clear, word stream and result counters.
// Used unchanged with or without ENC_CHK_ERR_INJ_EN.
interface ddr_512b_enc_chk_ctrl_if #(
    parameter int DATA_WD = 64
);

    logic               chk_rst;
    logic               gen_vld;
    logic [DATA_WD-1:0] gen_data;
    logic [31:0]        chk_suc_cnt;
    logic [31:0]        chk_err_cnt;

    modport master (
        output chk_rst,
        output gen_vld,
        output gen_data,
        input  chk_suc_cnt,
        input  chk_err_cnt
    );

    modport slave (
        input  chk_rst,
        input  gen_vld,
        input  gen_data,
        output chk_suc_cnt,
        output chk_err_cnt
    );

endinterface

// File: rtl/cmip_app_cnt.sv
// Generic clearable event counter.
// Independent of ENC_CHK_ERR_INJ_EN.
module cmip_app_cnt #(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [WD-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ddr_enc_pat_gen.sv
// Sequence-numbered word generator for the checker self-test.
// ENC_CHK_ERR_INJ_EN adds single-word seq[0] corruption.
module ddr_enc_pat_gen
    import ddr_enc_chk_pkg::*;
#(
    parameter int DATA_WD = 64
`ifdef ENC_CHK_ERR_INJ_EN
    ,
    parameter int LEN_WD = 32
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
`ifdef ENC_CHK_ERR_INJ_EN
    input  logic               inj_en,
    input  logic [LEN_WD-1:0]  inj_idx,
`endif
    output logic [DATA_WD-1:0] gen_data
);

    logic [SEQ_WD-1:0]         seq;
    logic [DATA_WD-SEQ_WD-1:0] pat_w;
    logic                      flip;

    // seq wraps at 16 bits, same as the checker's expected count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (clr) begin
            seq <= '0;
        end else if (step) begin
            seq <= seq + 1'b1;
        end
    end

    for (genvar i = 0; i < DATA_WD - SEQ_WD; i++) begin : g_pat
        assign pat_w[i] = PAT[i % PAT_WD];
    end

`ifdef ENC_CHK_ERR_INJ_EN
    logic [LEN_WD-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
        end
    end

    assign flip = inj_en && (idx == inj_idx);
`else
    assign flip = 1'b0;
`endif

    assign gen_data = step ? {pat_w, seq ^ SEQ_WD'(flip)} : '0;

endmodule

// File: rtl/ddr_512b_enc_chk_ctrl.sv
// Self-test sequencer: clears the checker, streams words, judges counters.
// Define ENC_CHK_ERR_INJ_EN for the cfg_inj_en / cfg_inj_idx injection feature.
module ddr_512b_enc_chk_ctrl
    import ddr_enc_chk_pkg::*;
#(
    parameter int DATA_WD   = 64,
    parameter int LEN_WD    = 32,
    parameter int DRAIN_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [LEN_WD-1:0]     cfg_pkt_num,
    input  logic [7:0]            cfg_gap,
`ifdef ENC_CHK_ERR_INJ_EN
    input  logic                  cfg_inj_en,
    input  logic [LEN_WD-1:0]     cfg_inj_idx,
`endif
    ddr_512b_enc_chk_ctrl_if.master chk,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [LEN_WD-1:0]     sent_cnt
);

    localparam int DR_WD  = $clog2(DRAIN_CYC);
    localparam int CNT_WD = max_i(8, DR_WD);
    localparam int CMP_WD = max_i(LEN_WD, 32);
    localparam logic [CNT_WD-1:0] DRAIN_LD = CNT_WD'(DRAIN_CYC - 1);

    ctrl_st_e          st, st_nxt;
    logic [CNT_WD-1:0] cnt, cnt_nxt;
    logic [LEN_WD-1:0] pkt_q;
    logic [7:0]        gap_q;
    logic              abt_done;
    logic              start_acc;
    logic              last_word;
    logic              sending;
    logic [CMP_WD-1:0] suc_x, pkt_x;
    logic              norm_ok, pass_ok;

    assign start_acc = (st == IDLE) && cfg_start && !cfg_abort;
    assign sending   = (st == SEND);
    assign last_word = (sent_cnt == pkt_q - 1'b1);

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        unique case (st)
            IDLE: begin
                if (start_acc) st_nxt = CLR;
            end
            CLR: begin
                if (pkt_q == '0) begin
                    st_nxt  = DRAIN;
                    cnt_nxt = DRAIN_LD;
                end else begin
                    st_nxt = SEND;
                end
            end
            SEND: begin
                if (last_word) begin
                    st_nxt  = DRAIN;
                    cnt_nxt = DRAIN_LD;
                end else if (gap_q != '0) begin
                    st_nxt  = GAP;
                    cnt_nxt = CNT_WD'(gap_q);
                end
            end
            GAP: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_WD'(1)) st_nxt = SEND;
            end
            DRAIN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) st_nxt = EVAL;
            end
            EVAL: begin
                st_nxt = IDLE;
            end
            default: begin
                st_nxt = IDLE;
            end
        endcase
        if (cfg_abort && (st != IDLE)) st_nxt = IDLE;
    end

    // counters are judged at their natural widths, zero-extended
    assign suc_x   = CMP_WD'(chk.chk_suc_cnt);
    assign pkt_x   = CMP_WD'(pkt_q);
    assign norm_ok = (chk.chk_err_cnt == '0) && (suc_x == pkt_x);

`ifdef ENC_CHK_ERR_INJ_EN
    logic              inj_en_q;
    logic [LEN_WD-1:0] inj_idx_q;
    logic              inj_act;
    logic              inj_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_en_q  <= 1'b0;
            inj_idx_q <= '0;
        end else if (start_acc) begin
            inj_en_q  <= cfg_inj_en;
            inj_idx_q <= cfg_inj_idx;
        end
    end

    assign inj_act = inj_en_q && (inj_idx_q < pkt_q);
    assign inj_ok  = (chk.chk_err_cnt == 32'd1) && (suc_x == pkt_x - 1'b1);
    assign pass_ok = inj_act ? inj_ok : norm_ok;
`else
    assign pass_ok = norm_ok;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            pkt_q    <= '0;
            gap_q    <= '0;
            pass     <= 1'b0;
            abt_done <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            abt_done <= cfg_abort && (st != IDLE) && (st != EVAL);
            if (start_acc) begin
                pkt_q <= cfg_pkt_num;
                gap_q <= cfg_gap;
                pass  <= 1'b0;
            end else if (st == EVAL) begin
                pass <= pass_ok && !cfg_abort;
            end
        end
    end

    assign chk.chk_rst = (st == CLR);
    assign chk.gen_vld = sending;
    assign busy        = (st != IDLE);
    assign done        = (st == EVAL) || abt_done;

    cmip_app_cnt #(
        .WD (LEN_WD)
    ) u_sent_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .inc   (sending),
        .cnt   (sent_cnt)
    );

    ddr_enc_pat_gen #(
        .DATA_WD (DATA_WD)
`ifdef ENC_CHK_ERR_INJ_EN
        ,
        .LEN_WD  (LEN_WD)
`endif
    ) u_pat_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .step     (sending),
`ifdef ENC_CHK_ERR_INJ_EN
        .inj_en   (inj_en_q),
        .inj_idx  (inj_idx_q),
`endif
        .gen_data (chk.gen_data)
    );

endmodule

// File: tb/tb_ddr_512b_enc_chk_ctrl.sv
// Bench for the self-test sequencer with a behavioural checker attached.
// Build with ENC_CHK_ERR_INJ_EN defined to cover error injection too.
`timescale 1ns/1ps
module tb_ddr_512b_enc_chk_ctrl;

    localparam int DATA_WD   = 64;
    localparam int LEN_WD    = 32;
    localparam int DRAIN_CYC = 16;
    localparam int HI_WD     = DATA_WD - 16;
    localparam int REP       = (HI_WD + 47) / 48;
    localparam logic [47:0] PAT48 = 48'hBBBB_CCCC_DDDD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [LEN_WD-1:0] cfg_pkt_num = '0;
    logic [7:0]        cfg_gap = '0;
`ifdef ENC_CHK_ERR_INJ_EN
    logic              cfg_inj_en = 1'b0;
    logic [LEN_WD-1:0] cfg_inj_idx = '0;
`endif
    logic              busy, done, pass;
    logic [LEN_WD-1:0] sent_cnt;

    bit inj_en_v  = 1'b0;
    int inj_idx_v = 0;

    ddr_512b_enc_chk_ctrl_if #(.DATA_WD(DATA_WD)) chk_if ();

    ddr_512b_enc_chk_ctrl #(
        .DATA_WD   (DATA_WD),
        .LEN_WD    (LEN_WD),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_gap     (cfg_gap),
`ifdef ENC_CHK_ERR_INJ_EN
        .cfg_inj_en  (cfg_inj_en),
        .cfg_inj_idx (cfg_inj_idx),
`endif
        .chk         (chk_if),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .sent_cnt    (sent_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural checker: expects PAT upper bits and a 16-bit running count
    logic [REP*48-1:0] rep_pat;
    logic [HI_WD-1:0]  exp_hi;
    logic [31:0]       m_suc, m_err;
    logic [15:0]       m_seq;

    assign rep_pat = {REP{PAT48}};
    assign exp_hi  = rep_pat[HI_WD-1:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_suc <= '0; m_err <= '0; m_seq <= '0;
        end else if (chk_if.chk_rst) begin
            m_suc <= '0; m_err <= '0; m_seq <= '0;
        end else if (chk_if.gen_vld) begin
            if (chk_if.gen_data === {exp_hi, m_seq}) m_suc <= m_suc + 1;
            else m_err <= m_err + 1;
            m_seq <= m_seq + 1'b1;
        end
    end

    assign chk_if.chk_suc_cnt = m_suc;
    assign chk_if.chk_err_cnt = m_err;

    int vld_q[$], lo_q[$], rst_q[$], done_q[$];
    int hi_bad = 0, overlap = 0;

    always @(negedge clk) begin
        if (chk_if.gen_vld) begin
            vld_q.push_back(cyc);
            lo_q.push_back(int'(chk_if.gen_data[15:0]));
            if (chk_if.gen_data[DATA_WD-1:16] !== exp_hi) hi_bad++;
        end
        if (chk_if.chk_rst) rst_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (chk_if.gen_vld && chk_if.chk_rst) overlap++;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        vld_q.delete(); lo_q.delete(); rst_q.delete(); done_q.delete();
        hi_bad = 0;
    endtask

    // abort_m >= 0: abort in the gap right after word abort_m
    task automatic run(input int n, input int g, input int abort_m, input bit exp_pass);
        int t0, lim, ab_cyc, ne, exp_done, bad, exp_lo;
        bit inj_act;
        @(posedge clk); #1;
        clr_mon();
        cfg_pkt_num = LEN_WD'(n);
        cfg_gap     = 8'(g);
        cfg_start   = 1'b1;
`ifdef ENC_CHK_ERR_INJ_EN
        cfg_inj_en  = inj_en_v;
        cfg_inj_idx = LEN_WD'(inj_idx_v);
`endif
        t0 = cyc;
        @(posedge clk); #1;
        cfg_start   = 1'b0;
        cfg_pkt_num = $urandom;
        cfg_gap     = 8'($urandom);
`ifdef ENC_CHK_ERR_INJ_EN
        cfg_inj_en  = ~inj_en_v;
        cfg_inj_idx = $urandom;
`endif
        @(negedge clk);
        chk("busy_at_clr", busy, 1);
        chk("pass_clr_on_start", pass, 0);
        ab_cyc = (abort_m >= 0) ? t0 + 2 + abort_m * (g + 1) + 1 : -1;
        lim = t0 + 2 + n * (g + 1) + DRAIN_CYC + 20;
        while (done_q.size() == 0 && cyc < lim) begin
            @(posedge clk); #1;
            cfg_abort = (cyc == ab_cyc);
        end
        cfg_abort = 1'b0;
        chk("done_seen", done_q.size() > 0, 1);
        chk("pass", pass, exp_pass);
        chk("busy_after", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        ne = (abort_m >= 0) ? abort_m + 1 : n;
        if (abort_m >= 0) exp_done = ab_cyc + 1;
        else if (n == 0) exp_done = t0 + 2 + DRAIN_CYC;
        else exp_done = t0 + 2 + n * (g + 1) - g + DRAIN_CYC;
        chk("done_cnt", done_q.size(), 1);
        chk("done_cyc", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        chk("rst_cnt", rst_q.size(), 1);
        chk("rst_cyc", (rst_q.size() > 0) ? rst_q[0] : -1, t0 + 1);
        chk("vld_cnt", vld_q.size(), ne);
        inj_act = inj_en_v && (inj_idx_v < n);
        bad = 0;
        foreach (vld_q[k]) begin
            exp_lo = (k % 65536) ^ ((inj_act && k == inj_idx_v) ? 1 : 0);
            if (vld_q[k] != t0 + 2 + k * (g + 1) || lo_q[k] != exp_lo) bad++;
        end
        chk("word_sched_data", bad, 0);
        chk("word_hi_pat", hi_bad, 0);
        chk("sent_cnt", sent_cnt, ne);
        if (abort_m < 0) begin
            chk("chk_err", m_err, inj_act ? 1 : 0);
            chk("chk_suc", m_suc, n - (inj_act ? 1 : 0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_vld", chk_if.gen_vld, 0);
        chk("rst_chk_rst", chk_if.chk_rst, 0);
        chk("rst_data", chk_if.gen_data, 0);
        rst_n = 1'b1;

        run(8, 0, -1, 1'b1);
        run(3, 4, -1, 1'b1);
        run(0, int'($urandom_range(0, 7)), -1, 1'b1);

        // abort alone, then start together with abort: nothing may start
        @(posedge clk); #1;
        clr_mon();
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rst", rst_q.size(), 0);
        chk("idle_abort_done", done_q.size(), 0);
        chk("idle_pass_held", pass, 1);

        run(100, int'($urandom_range(2, 6)), int'($urandom_range(3, 10)), 1'b0);
        run(5, int'($urandom_range(0, 3)), -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            run(int'($urandom_range(1, 40)), int'($urandom_range(0, 5)), -1, 1'b1);
        end

        run(65536 + int'($urandom_range(1, 8)), 0, -1, 1'b1);

`ifdef ENC_CHK_ERR_INJ_EN
        inj_en_v  = 1'b1;
        inj_idx_v = 4;
        run(10, 1, -1, 1'b1);
        inj_idx_v = 12;
        run(10, 0, -1, 1'b1);
        inj_en_v  = 1'b0;
`endif

        chk("vld_rst_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
